// File: rtl/lcd_timing_gen.sv
// Parallel RGB LCD timing generator with PLL-lock power-up sequencing.
// Outputs are registered from the next-cycle counter values, so all of them describe the same (h,v).
module lcd_timing_gen #(
  parameter int H_ACTIVE  = 480,
  parameter int H_FP      = 2,
  parameter int H_SYNC    = 41,
  parameter int H_BP      = 2,
  parameter int V_ACTIVE  = 272,
  parameter int V_FP      = 2,
  parameter int V_SYNC    = 10,
  parameter int V_BP      = 2,
  parameter int LOCK_WAIT = 1024,
  parameter int PWR_DELAY = 4096
) (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic       pll_locked_i,
  output logic       hsync_o,
  output logic       vsync_o,
  output logic       de_o,
  output logic [9:0] x_o,
  output logic [9:0] y_o,
  output logic       frame_start_o,
  output logic       disp_en_o,
  output logic       bl_en_o,
  output logic       running_o,
  output logic [1:0] state_o
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int CNT_MAX = (LOCK_WAIT > PWR_DELAY) ? LOCK_WAIT : PWR_DELAY;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_ACT  = 11'(H_ACTIVE);
  localparam logic [10:0] V_ACT  = 11'(V_ACTIVE);
  localparam logic [10:0] HS_BEG = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VS_BEG = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END = 11'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic [CW-1:0] LOCK_DONE = CW'(LOCK_WAIT);
  localparam logic [CW-1:0] PWR_DONE  = CW'(PWR_DELAY - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_PWR_ON = 2'd2,
    S_RUN    = 2'd3
  } state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [10:0]   h_q, v_q;

  logic [10:0] h_d, v_d;
  logic        de_d, hs_d, vs_d, fs_d;
  logic        load_run;
  logic        go_safe;

  // Outside RUN the next position is (0,0), which is exactly the first RUN pixel.
  always_comb begin
    h_d = '0;
    v_d = '0;
    if (state_q == S_RUN) begin
      if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? 11'd0 : v_q + 11'd1;
      end else begin
        h_d = h_q + 11'd1;
        v_d = v_q;
      end
    end
    de_d = (h_d < H_ACT) && (v_d < V_ACT);
    hs_d = !((h_d >= HS_BEG) && (h_d < HS_END));
    vs_d = !((v_d >= VS_BEG) && (v_d < VS_END));
    fs_d = (h_d == 11'd0) && (v_d == 11'd0);
  end

  assign load_run = (state_q == S_RUN) || ((state_q == S_PWR_ON) && (cnt_q == PWR_DONE));
  assign go_safe  = reset_i || ((state_q != S_IDLE) && !pll_locked_i);
  assign state_o  = state_q;

  always_ff @(posedge clock_i) begin
    if (go_safe) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      h_q           <= '0;
      v_q           <= '0;
      hsync_o       <= 1'b1;
      vsync_o       <= 1'b1;
      de_o          <= 1'b0;
      x_o           <= '0;
      y_o           <= '0;
      frame_start_o <= 1'b0;
      disp_en_o     <= 1'b0;
      bl_en_o       <= 1'b0;
      running_o     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          cnt_q <= '0;
          if (pll_locked_i) state_q <= S_SETTLE;
        end
        S_SETTLE: begin
          if (cnt_q == LOCK_DONE) begin
            state_q   <= S_PWR_ON;
            cnt_q     <= '0;
            disp_en_o <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        S_PWR_ON: begin
          if (cnt_q == PWR_DONE) begin
            state_q   <= S_RUN;
            cnt_q     <= '0;
            running_o <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        S_RUN: begin
          // Only a wrap back to (0,0) can raise fs_d here, i.e. the second frame start onward.
          bl_en_o <= bl_en_o | fs_d;
        end
        default: state_q <= S_IDLE;
      endcase
      if (load_run) begin
        h_q           <= h_d;
        v_q           <= v_d;
        hsync_o       <= hs_d;
        vsync_o       <= vs_d;
        de_o          <= de_d;
        x_o           <= de_d ? h_d[9:0] : 10'd0;
        y_o           <= de_d ? v_d[9:0] : 10'd0;
        frame_start_o <= fs_d;
      end
    end
  end

endmodule

// File: tb/tb_lcd_timing_gen.sv
// Bench for lcd_timing_gen with a small raster: 15 cycles/line, 8 lines/frame, 120 cycles/frame.
module tb_lcd_timing_gen;

  localparam int LW = 8;
  localparam int PD = 16;
  localparam int W  = 100;

  localparam logic [3:0] K_DISP  = 4'd1;
  localparam logic [3:0] K_FS    = 4'd2;
  localparam logic [3:0] K_BL    = 4'd3;
  localparam logic [3:0] K_SAFE  = 4'd4;
  localparam logic [3:0] K_STATS = 4'd5;

  // Frame statistics for 8+2+3+2 by 4+1+2+1:
  // 32 de cycles, 120-cycle period, sum x = 4*28, sum y = 8*(0+1+2+3);
  // hsync first low at h=10, 3 cycles x 8 lines; vsync first low at line 5 (offset 75), 2 lines x 15.
  localparam logic [31:0] STATS_A = {8'd32, 8'd120, 8'd112, 8'd48};
  localparam logic [31:0] STATS_B = {8'd10, 8'd24, 8'd75, 8'd30};
  localparam logic [31:0] FS_B0   = 32'b111101;  // {de,hs,vs,run,bl,disp}, backlight off
  localparam logic [31:0] FS_B1   = 32'b111111;  // backlight on
  localparam logic [31:0] DISP_A  = 32'd2;       // {running=0, state=PWR_ON}
  localparam logic [31:0] SAFE_A  = 32'h0C0;     // {de0,hs1,vs1,fs0,disp0,bl0,run0,state=IDLE}

  logic       clk = 1'b0;
  logic       reset;
  logic       locked;
  logic       hsync, vsync, de, frame_start, disp_en, bl_en, running;
  logic [9:0] x, y;
  logic [1:0] state;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  lcd_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .LOCK_WAIT(LW), .PWR_DELAY(PD)
  ) dut (
    .clock_i      (clk),
    .reset_i      (reset),
    .pll_locked_i (locked),
    .hsync_o      (hsync),
    .vsync_o      (vsync),
    .de_o         (de),
    .x_o          (x),
    .y_o          (y),
    .frame_start_o(frame_start),
    .disp_en_o    (disp_en),
    .bl_en_o      (bl_en),
    .running_o    (running),
    .state_o      (state)
  );

  // clock / cycle counter: at each negedge, cyc equals the number of posedges so far
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [W-1:0] mk(input logic [3:0] k, input int c,
                                      input logic [31:0] a, input logic [31:0] b);
    return {k, 32'(c), a, b};
  endfunction

  task automatic expect_ev(input logic [3:0] k, input int c,
                           input logic [31:0] a, input logic [31:0] b);
    exp_q.push_back(mk(k, c, a, b));
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  // scoreboard compare, called by the monitor whenever the DUT presents an event
  task automatic got_ev(input logic [W-1:0] g);
    logic [W-1:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event kind=%0d got=%h exp=none", g[99:96], g);
    end else begin
      e = exp_q.pop_front();
      if (g !== e) begin
        errors++;
        $display("FAIL event_kind%0d got=%h exp=%h", g[99:96], g, e);
      end
    end
  endtask

  // monitor
  initial begin
    logic prev_disp, prev_run, prev_bl, fs_seen;
    int period, de_cnt, xsum, ysum, hs_first, hs_low, vs_first, vs_low;
    prev_disp = 1'b0; prev_run = 1'b0; prev_bl = 1'b0; fs_seen = 1'b0;
    period = 0; de_cnt = 0; xsum = 0; ysum = 0;
    hs_first = -1; hs_low = 0; vs_first = -1; vs_low = 0;
    forever begin
      @(negedge clk);
      checks++;
      if (!running) begin
        if (de || !hsync || !vsync || x != 10'd0 || y != 10'd0 || frame_start || bl_en) begin
          errors++;
          $display("FAIL idle_outputs cyc=%0d got de=%b hs=%b vs=%b x=%0d y=%0d fs=%b bl=%b exp 0 1 1 0 0 0 0",
                   cyc, de, hsync, vsync, x, y, frame_start, bl_en);
        end
      end else if (!de && (x != 10'd0 || y != 10'd0)) begin
        errors++;
        $display("FAIL blank_xy cyc=%0d got x=%0d y=%0d exp 0 0", cyc, x, y);
      end
      if (running && frame_start) begin
        if (fs_seen)
          got_ev(mk(K_STATS, cyc, {8'(de_cnt), 8'(period), 8'(xsum), 8'(ysum)},
                    {8'(hs_first), 8'(hs_low), 8'(vs_first), 8'(vs_low)}));
        got_ev(mk(K_FS, cyc, {12'd0, x, y}, {26'd0, de, hsync, vsync, running, bl_en, disp_en}));
        fs_seen = 1'b1;
        period = 0; de_cnt = 0; xsum = 0; ysum = 0;
        hs_first = -1; hs_low = 0; vs_first = -1; vs_low = 0;
      end
      if (bl_en && !prev_bl) got_ev(mk(K_BL, cyc, {12'd0, x, y}, 32'd0));
      if (disp_en && !prev_disp) got_ev(mk(K_DISP, cyc, {29'd0, running, state}, 32'd0));
      if (!running && prev_run) begin
        got_ev(mk(K_SAFE, cyc, {23'd0, de, hsync, vsync, frame_start, disp_en, bl_en, running, state},
                  {12'd0, x, y}));
        fs_seen = 1'b0;
      end
      if (running) begin
        if (de) begin
          de_cnt++;
          xsum += int'(x);
          ysum += int'(y);
        end
        if (!hsync) begin
          if (hs_first < 0) hs_first = period;
          hs_low++;
        end
        if (!vsync) begin
          if (vs_first < 0) vs_first = period;
          vs_low++;
        end
        period++;
      end
      prev_disp = disp_en;
      prev_run  = running;
      prev_bl   = bl_en;
    end
  end

  // stimulus: each value driven at a negedge is sampled by the DUT at edge cyc+1
  initial begin
    int c0, f0, c1, f2, c2, f3;
    reset  = 1'b1;
    locked = 1'b1;
    wait_until(4);

    checks++;
    if ({hsync, vsync, de, x, y, frame_start, disp_en, bl_en, running, state} !==
        {1'b1, 1'b1, 1'b0, 10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0}) begin
      errors++;
      $display("FAIL reset_values got hs=%b vs=%b de=%b x=%0d y=%0d fs=%b disp=%b bl=%b run=%b st=%0d exp 1 1 0 0 0 0 0 0 0 0",
               hsync, vsync, de, x, y, frame_start, disp_en, bl_en, running, state);
    end

    // reset released with lock held: disp_en LW+1 after the first lock sample, first pixel PD later
    c0 = cyc;
    f0 = c0 + 1 + LW + 1 + PD;
    expect_ev(K_DISP, c0 + LW + 2, DISP_A, 32'd0);
    expect_ev(K_FS, f0, 32'd0, FS_B0);
    expect_ev(K_STATS, f0 + 120, STATS_A, STATS_B);
    expect_ev(K_FS, f0 + 120, 32'd0, FS_B1);
    expect_ev(K_BL, f0 + 120, 32'd0, 32'd0);
    expect_ev(K_STATS, f0 + 240, STATS_A, STATS_B);
    expect_ev(K_FS, f0 + 240, 32'd0, FS_B1);
    reset = 1'b0;

    // lock lost while frame 2 shows (5,2)
    wait_until(f0 + 240 + 2 * 15 + 5);
    locked = 1'b0;
    expect_ev(K_SAFE, cyc + 1, SAFE_A, 32'd0);

    // re-lock with a one-cycle glitch while the settle count is 5
    wait_until(cyc + 3);
    c1 = cyc;
    locked = 1'b1;
    wait_until(c1 + 6);
    locked = 1'b0;
    wait_until(c1 + 7);
    locked = 1'b1;
    f2 = c1 + 8 + LW + 1 + PD;
    expect_ev(K_DISP, c1 + 8 + LW + 1, DISP_A, 32'd0);
    expect_ev(K_FS, f2, 32'd0, FS_B0);

    // synchronous reset while showing (7,2)
    wait_until(f2 + 2 * 15 + 7);
    reset = 1'b1;
    expect_ev(K_SAFE, cyc + 1, SAFE_A, 32'd0);
    wait_until(cyc + 1);
    c2 = cyc;
    reset = 1'b0;
    f3 = c2 + 1 + LW + 1 + PD;
    expect_ev(K_DISP, c2 + LW + 2, DISP_A, 32'd0);
    expect_ev(K_FS, f3, 32'd0, FS_B0);
    expect_ev(K_STATS, f3 + 120, STATS_A, STATS_B);
    expect_ev(K_FS, f3 + 120, 32'd0, FS_B1);
    expect_ev(K_BL, f3 + 120, 32'd0, 32'd0);

    wait_until(f3 + 130);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_events got pending=%0d exp 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
